axi_mst_wr_stream: RTL and testbench

AXI_MST_WR_STREAM -- requirements
Module: axi_mst_wr_stream

---
 rtl/axi_mst_wr_stream.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_mst_wr_stream.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mst_wr_stream.sv
// AXI-Stream to AXI4 write master: buffers stream beats and issues INCR bursts to a base address.
// Optional 4 KB boundary splitting when AXI_MST_WR_4K_SPLIT_EN is defined.
module axi_mst_wr_stream #(
    parameter int ID_WIDTH   = 6,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_OUTST  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    START_REG,
    input  logic [ADDR_WIDTH-1:0]   ADDR_REG,
    input  logic [31:0]             NBEATS_REG,
    output logic                    IDLE_REG,
    output logic                    ERR_REG
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SIZE   = $clog2(STRB_W);
    localparam int FPW    = $clog2(FIFO_DEPTH);
    localparam int FCW    = FPW + 1;
    localparam int QPW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int QCW    = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e r_state, w_state_d;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_awlen;
    logic                  r_awvalid;
    logic [31:0]           r_nbeats, r_accepted, r_unissued;
    logic [FCW-1:0]        r_reserved;
    logic [QCW-1:0]        r_outst;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [STRB_W-1:0]     r_mem_strb [FIFO_DEPTH];
    logic [FPW-1:0]        r_fwr, r_frd;
    logic [FCW-1:0]        r_fcnt;

    logic [7:0]            r_qlen [MAX_OUTST];
    logic [QPW-1:0]        r_qwr, r_qrd;
    logic [QCW-1:0]        r_qcnt;
    logic [7:0]            r_wbeat;

    logic                  w_start, w_push, w_tready, w_wvalid, w_wlast, w_wfire;
    logic                  w_aw_fire, w_b_fire, w_bready, w_issue_ok, w_qpop;
    logic [31:0]           w_beats, w_avail, w_aw_beats;
    logic [7:0]            w_len;
    logic [ADDR_WIDTH-1:0] w_addr_inc;

    assign w_start    = (r_state == StIdle) && START_REG;
    assign w_tready   = (r_state == StRun) && (r_fcnt != FCW'(FIFO_DEPTH))
                        && (r_accepted < r_nbeats);
    assign w_push     = s_axis_tvalid && w_tready;
    assign w_wvalid   = (r_qcnt != '0);
    assign w_wlast    = w_wvalid && (r_wbeat == r_qlen[r_qrd]);
    assign w_wfire    = w_wvalid && m_axi_wready;
    assign w_qpop     = w_wfire && w_wlast;
    assign w_aw_fire  = r_awvalid && m_axi_awready;
    assign w_bready   = (r_state == StRun) || (r_state == StDrain);
    assign w_b_fire   = m_axi_bvalid && w_bready;
    assign w_aw_beats = {24'd0, r_awlen} + 32'd1;
    assign w_addr_inc = ADDR_WIDTH'({1'b0, r_awlen} + 9'd1) << SIZE;
    assign w_avail    = 32'(r_fcnt) - 32'(r_reserved);

`ifdef AXI_MST_WR_4K_SPLIT_EN
    logic [12:0] w_4k_room;
    logic [31:0] w_4k_beats;
    assign w_4k_room  = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_4k_beats = 32'(w_4k_room >> SIZE);
`endif

    always_comb begin
        w_beats = (r_unissued < 32'(BURST_LEN)) ? r_unissued : 32'(BURST_LEN);
`ifdef AXI_MST_WR_4K_SPLIT_EN
        if (w_4k_beats < w_beats) begin
            w_beats = w_4k_beats;
        end
`endif
        w_len = 8'(w_beats - 32'd1);
    end

    // Only buffered beats not already promised to an earlier burst can back a new AW.
    assign w_issue_ok = (r_state == StRun) && !r_awvalid && (r_unissued != 32'd0)
                        && (w_avail >= w_beats) && (r_outst < QCW'(MAX_OUTST));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (START_REG) w_state_d = (NBEATS_REG == 32'd0) ? StDone : StRun;
            StRun:   if (w_aw_fire && (r_unissued == w_aw_beats)) w_state_d = StDrain;
            StDrain: if ((r_outst == '0) && (r_qcnt == '0)) w_state_d = StDone;
            StDone:  if (!START_REG) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr     <= '0;
            r_awlen    <= '0;
            r_awvalid  <= 1'b0;
            r_nbeats   <= '0;
            r_accepted <= '0;
            r_unissued <= '0;
            r_reserved <= '0;
            r_outst    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr     <= ADDR_REG;
                r_nbeats   <= NBEATS_REG;
                r_unissued <= NBEATS_REG;
                r_accepted <= '0;
                r_err      <= 1'b0;
            end else begin
                if (w_push) begin
                    r_accepted <= r_accepted + 32'd1;
                end
                if (w_aw_fire) begin
                    r_addr     <= r_addr + w_addr_inc;
                    r_unissued <= r_unissued - w_aw_beats;
                end
                if (w_b_fire && (m_axi_bresp != 2'b00)) begin
                    r_err <= 1'b1;
                end
            end
            if (w_aw_fire) begin
                r_awvalid <= 1'b0;
            end else if (w_issue_ok) begin
                r_awvalid <= 1'b1;
                r_awlen   <= w_len;
            end
            r_reserved <= r_reserved + (w_aw_fire ? FCW'(r_awlen) + FCW'(1) : '0)
                          - (w_wfire ? FCW'(1) : '0);
            unique case ({w_aw_fire, w_b_fire})
                2'b10:   r_outst <= r_outst + QCW'(1);
                2'b01:   r_outst <= r_outst - QCW'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fwr   <= '0;
            r_frd   <= '0;
            r_fcnt  <= '0;
            r_qwr   <= '0;
            r_qrd   <= '0;
            r_qcnt  <= '0;
            r_wbeat <= '0;
        end else begin
            if (w_push) begin
                r_fwr <= r_fwr + FPW'(1);
            end
            if (w_wfire) begin
                r_frd   <= r_frd + FPW'(1);
                r_wbeat <= w_wlast ? 8'd0 : r_wbeat + 8'd1;
            end
            r_fcnt <= r_fcnt + (w_push ? FCW'(1) : '0) - (w_wfire ? FCW'(1) : '0);
            if (w_aw_fire) begin
                r_qwr <= (r_qwr == QPW'(MAX_OUTST - 1)) ? '0 : r_qwr + QPW'(1);
            end
            if (w_qpop) begin
                r_qrd <= (r_qrd == QPW'(MAX_OUTST - 1)) ? '0 : r_qrd + QPW'(1);
            end
            r_qcnt <= r_qcnt + (w_aw_fire ? QCW'(1) : '0) - (w_qpop ? QCW'(1) : '0);
        end
    end

    // Storage arrays carry no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_fwr] <= s_axis_tdata;
            r_mem_strb[r_fwr] <= s_axis_tstrb;
        end
        if (w_aw_fire) begin
            r_qlen[r_qwr] <= r_awlen;
        end
    end

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_mem_data[r_frd];
    assign m_axi_wstrb   = r_mem_strb[r_frd];
    assign m_axi_wlast   = w_wlast;
    assign m_axi_wvalid  = w_wvalid;
    assign m_axi_bready  = w_bready;
    assign s_axis_tready = w_tready;
    assign IDLE_REG      = (r_state == StIdle);
    assign ERR_REG       = r_err;

endmodule

// File: tb/tb_axi_mst_wr_stream.sv
// Scoreboard bench for axi_mst_wr_stream: expected AW/W traffic is queued as stimulus is driven.
`timescale 1ns/1ps
module tb_axi_mst_wr_stream;

    localparam int IDW = 6;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int BL  = 16;
    localparam int SW  = DW / 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [IDW-1:0] m_axi_awid;
    logic [AW-1:0]  m_axi_awaddr;
    logic [7:0]     m_axi_awlen;
    logic [2:0]     m_axi_awsize;
    logic [1:0]     m_axi_awburst;
    logic           m_axi_awvalid;
    logic           m_axi_awready = 1'b1;
    logic [DW-1:0]  m_axi_wdata;
    logic [SW-1:0]  m_axi_wstrb;
    logic           m_axi_wlast, m_axi_wvalid;
    logic           m_axi_wready = 1'b1;
    logic [1:0]     m_axi_bresp = 2'b00;
    logic           m_axi_bvalid = 1'b0;
    logic           m_axi_bready;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic [SW-1:0]  s_axis_tstrb = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic           START_REG = 1'b0;
    logic [AW-1:0]  ADDR_REG = '0;
    logic [31:0]    NBEATS_REG = '0;
    logic           IDLE_REG, ERR_REG;

    axi_mst_wr_stream #(
        .ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .BURST_LEN(BL), .FIFO_DEPTH(64), .MAX_OUTST(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .START_REG(START_REG), .ADDR_REG(ADDR_REG), .NBEATS_REG(NBEATS_REG),
        .IDLE_REG(IDLE_REG), .ERR_REG(ERR_REG)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } w_t;

    aw_t aw_q[$];
    w_t  w_q[$];
    bit  last_map[$];

    int total = 0;
    int bad = 0;
    int aw_cnt = 0, w_cnt = 0, w_done = 0, b_sent = 0, s_acc = 0;
    int aw_first_acc = 0, err_burst = 0;
    bit b_enable = 1'b1, chk_en = 1'b1, slave_rand = 1'b0, w_in_burst = 1'b0;
    bit b_fire_pend = 1'b0, awv_prev = 1'b0;
    aw_t aw_prev;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // AW channel: scoreboard pop plus hold-until-ready check.
    always @(negedge clk) begin
        aw_t e;
        if (rstn && chk_en) begin
            if (awv_prev) begin
                total++;
                if (!m_axi_awvalid || {m_axi_awaddr, m_axi_awlen} !== aw_prev) begin
                    bad++;
                    $display("FAIL aw_stable: got valid=%b addr=%h len=%0d want valid=1 addr=%h len=%0d",
                             m_axi_awvalid, m_axi_awaddr, m_axi_awlen, aw_prev.addr, aw_prev.len);
                end
            end
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_cnt == 0) aw_first_acc = s_acc;
                total++;
                if (aw_q.size() == 0) begin
                    bad++;
                    $display("FAIL aw_unexpected: got addr=%h len=%0d want none",
                             m_axi_awaddr, m_axi_awlen);
                end else begin
                    e = aw_q.pop_front();
                    if ({m_axi_awaddr, m_axi_awlen, m_axi_awid, m_axi_awsize, m_axi_awburst}
                        !== {e.addr, e.len, 6'd0, 3'd3, 2'b01}) begin
                        bad++;
                        $display("FAIL aw_beat: got addr=%h len=%0d id=%0d size=%0d burst=%0d want addr=%h len=%0d id=0 size=3 burst=1",
                                 m_axi_awaddr, m_axi_awlen, m_axi_awid, m_axi_awsize,
                                 m_axi_awburst, e.addr, e.len);
                    end
                end
            end
        end
        if (m_axi_awvalid && m_axi_awready) aw_cnt++;
        awv_prev = rstn && m_axi_awvalid && !m_axi_awready;
        aw_prev  = '{addr: m_axi_awaddr, len: m_axi_awlen};
    end

    // W channel: data/strobe/last scoreboard and no-gap-within-burst check.
    always @(negedge clk) begin
        w_t e;
        if (m_axi_wvalid && m_axi_wready) begin
            if (chk_en) begin
                total++;
                if (w_q.size() == 0) begin
                    bad++;
                    $display("FAIL w_unexpected: got data=%h want none", m_axi_wdata);
                end else begin
                    e = w_q.pop_front();
                    if ({m_axi_wdata, m_axi_wstrb, m_axi_wlast} !== {e.data, e.strb, e.last}) begin
                        bad++;
                        $display("FAIL w_beat: got data=%h strb=%h last=%b want data=%h strb=%h last=%b",
                                 m_axi_wdata, m_axi_wstrb, m_axi_wlast, e.data, e.strb, e.last);
                    end
                end
            end
            w_cnt++;
            if (m_axi_wlast) w_done++;
            w_in_burst = !m_axi_wlast;
        end else if (w_in_burst && chk_en && rstn) begin
            total++;
            if (m_axi_wvalid !== 1'b1) begin
                bad++;
                $display("FAIL w_gap: got wvalid=%b want 1 inside burst", m_axi_wvalid);
            end
        end
        b_fire_pend = m_axi_bvalid && m_axi_bready;
    end

    // Slave responder: one B per completed W burst, optional error on a chosen burst.
    always begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_axi_bvalid = 1'b0;
        end else if (b_fire_pend) begin
            m_axi_bvalid = 1'b0;
            b_sent++;
        end
        if (slave_rand) begin
            m_axi_awready = 1'($urandom_range(0, 1));
            m_axi_wready  = 1'($urandom_range(0, 1));
        end else begin
            m_axi_awready = 1'b1;
            m_axi_wready  = 1'b1;
        end
        if (rstn && !m_axi_bvalid && b_enable && b_sent < w_done) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (b_sent + 1 == err_burst) ? 2'b10 : 2'b00;
        end
    end

    task automatic plan(input logic [AW-1:0] addr, input int n, output int nb);
        logic [AW-1:0] a;
        int rem, b;
        a = addr;
        rem = n;
        nb = 0;
        aw_q.delete();
        w_q.delete();
        last_map.delete();
        while (rem > 0) begin
            b = (rem < BL) ? rem : BL;
`ifdef AXI_MST_WR_4K_SPLIT_EN
            if ((4096 - int'(a[11:0])) / SW < b) b = (4096 - int'(a[11:0])) / SW;
`endif
            aw_q.push_back('{addr: a, len: 8'(b - 1)});
            for (int i = 0; i < b; i++) last_map.push_back(i == b - 1);
            a = a + AW'(b * SW);
            rem -= b;
            nb++;
        end
    endtask

    task automatic start_xfer(input logic [AW-1:0] addr, input int n, output int nb);
        plan(addr, n, nb);
        aw_cnt = 0;
        s_acc = 0;
        b_sent = 0;
        w_done = 0;
        w_in_burst = 1'b0;
        @(posedge clk);
        #1;
        ADDR_REG = addr;
        NBEATS_REG = n;
        START_REG = 1'b1;
    endtask

    task automatic drive_stream(input int n, input int stall_at, input int stall_len,
                                input int budget);
        int i, c, st;
        bit need_new;
        i = 0;
        c = 0;
        st = stall_len;
        need_new = 1'b1;
        while (i < n && c < budget) begin
            @(posedge clk);
            #1;
            if (i == stall_at && st > 0) begin
                s_axis_tvalid = 1'b0;
                st--;
            end else if (need_new) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {$urandom, $urandom};
                s_axis_tstrb  = 8'($urandom);
                need_new = 1'b0;
            end
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) begin
                w_q.push_back('{data: s_axis_tdata, strb: s_axis_tstrb,
                                last: (s_acc < last_map.size()) ? last_map[s_acc] : 1'b0});
                s_acc++;
                i++;
                need_new = 1'b1;
            end
            c++;
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic finish_xfer(input string name, input int nb, input bit exp_err,
                               input int budget);
        int c;
        c = 0;
        while (!(aw_q.size() == 0 && w_q.size() == 0 && b_sent == nb) && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (c >= budget) begin
            bad++;
            $display("FAIL %s_timeout: got aw_left=%0d w_left=%0d b=%0d want 0 0 %0d",
                     name, aw_q.size(), w_q.size(), b_sent, nb);
        end
        total++;
        if (aw_cnt !== nb) begin
            bad++;
            $display("FAIL %s_aw_count: got %0d want %0d", name, aw_cnt, nb);
        end
        total++;
        if (IDLE_REG !== 1'b0 || ERR_REG !== exp_err || m_axi_awvalid || m_axi_wvalid) begin
            bad++;
            $display("FAIL %s_done: got idle=%b err=%b awv=%b wv=%b want idle=0 err=%b awv=0 wv=0",
                     name, IDLE_REG, ERR_REG, m_axi_awvalid, m_axi_wvalid, exp_err);
        end
        @(posedge clk);
        #1;
        START_REG = 1'b0;
        c = 0;
        while (IDLE_REG !== 1'b1 && c < 8) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (IDLE_REG !== 1'b1 || ERR_REG !== exp_err) begin
            bad++;
            $display("FAIL %s_idle: got idle=%b err=%b want idle=1 err=%b",
                     name, IDLE_REG, ERR_REG, exp_err);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready, ERR_REG,
             IDLE_REG, m_axi_awaddr, m_axi_awlen} !== {7'b0000001, 32'd0, 8'd0}) begin
            bad++;
            $display("FAIL reset_state: got awv=%b wv=%b wl=%b br=%b tr=%b err=%b idle=%b addr=%h len=%0d want 0 0 0 0 0 0 1 0 0",
                     m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready,
                     ERR_REG, IDLE_REG, m_axi_awaddr, m_axi_awlen);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int nb;
        start_xfer(32'h0000_1000, 64, nb);
        fork
            drive_stream(64, -1, 0, 2000);
            finish_xfer("basic", nb, 1'b0, 3000);
        join
    endtask

    task automatic test_short();
        int nb;
        start_xfer(32'h0000_2000, 20, nb);
        fork
            drive_stream(21, -1, 0, 200);
            finish_xfer("short", nb, 1'b0, 3000);
        join
        total++;
        if (s_acc !== 20) begin
            bad++;
            $display("FAIL short_accepted: got %0d beats want 20", s_acc);
        end
    endtask

    task automatic test_b_hold();
        int nb, viol;
        b_enable = 1'b0;
        start_xfer(32'h0000_4000, 128, nb);
        fork
            drive_stream(128, -1, 0, 3000);
            begin
                repeat (300) @(negedge clk);
                total++;
                if (aw_cnt !== 4) begin
                    bad++;
                    $display("FAIL bhold_aw_count: got %0d want 4", aw_cnt);
                end
                viol = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (m_axi_awvalid !== 1'b0) viol++;
                end
                total++;
                if (viol != 0) begin
                    bad++;
                    $display("FAIL bhold_awvalid: got %0d cycles high want 0", viol);
                end
                b_enable = 1'b1;
                finish_xfer("bhold", nb, 1'b0, 3000);
            end
        join
    endtask

    task automatic test_stall();
        int nb;
        slave_rand = 1'b1;
        start_xfer(32'h0000_6000, 32, nb);
        fork
            drive_stream(32, 10, 30, 2000);
            finish_xfer("stall", nb, 1'b0, 3000);
        join
        slave_rand = 1'b0;
        total++;
        if (aw_first_acc < 16) begin
            bad++;
            $display("FAIL stall_first_aw: got %0d beats buffered want >=16", aw_first_acc);
        end
    endtask

    task automatic test_error();
        int nb;
        err_burst = 2;
        start_xfer(32'h0000_8000, 48, nb);
        fork
            drive_stream(48, -1, 0, 2000);
            finish_xfer("err", nb, 1'b1, 3000);
        join
        err_burst = 0;
        start_xfer(32'h0000_9000, 16, nb);
        repeat (2) @(negedge clk);
        total++;
        if (ERR_REG !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got %b want 0", ERR_REG);
        end
        fork
            drive_stream(16, -1, 0, 2000);
            finish_xfer("err2", nb, 1'b0, 3000);
        join
    endtask

`ifdef AXI_MST_WR_4K_SPLIT_EN
    task automatic test_4k();
        int nb;
        start_xfer(32'h0000_0FC0, 16, nb);
        total++;
        if (nb !== 2) begin
            bad++;
            $display("FAIL split4k_plan: got %0d bursts want 2", nb);
        end
        fork
            drive_stream(16, -1, 0, 2000);
            finish_xfer("split4k", nb, 1'b0, 3000);
        join
    endtask
`endif

    task automatic test_reset_mid();
        int c, base, viol;
        chk_en = 1'b0;
        b_enable = 1'b0;
        base = w_cnt;
        @(posedge clk);
        #1;
        ADDR_REG = 32'h0000_A000;
        NBEATS_REG = 64;
        START_REG = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = {$urandom, $urandom};
        s_axis_tstrb = '1;
        c = 0;
        while (w_cnt < base + 5 && c < 300) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (c >= 300) begin
            bad++;
            $display("FAIL rstmid_progress: got %0d W beats want 5", w_cnt - base);
        end
        #1;
        rstn = 1'b0;
        START_REG = 1'b0;
        #1;
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready, ERR_REG,
             IDLE_REG, m_axi_awaddr, m_axi_awlen} !== {7'b0000001, 32'd0, 8'd0}) begin
            bad++;
            $display("FAIL rstmid_async: got awv=%b wv=%b wl=%b br=%b tr=%b err=%b idle=%b addr=%h len=%0d want 0 0 0 0 0 0 1 0 0",
                     m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready,
                     ERR_REG, IDLE_REG, m_axi_awaddr, m_axi_awlen);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_axi_awvalid || m_axi_wvalid || s_axis_tready || !IDLE_REG) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", viol);
        end
        s_axis_tvalid = 1'b0;
        w_in_burst = 1'b0;
        aw_q.delete();
        w_q.delete();
        b_enable = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_b_hold();
        test_stall();
        test_error();
`ifdef AXI_MST_WR_4K_SPLIT_EN
        test_4k();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
